packet_deserializer: RTL and testbench

PACKET_DESERIALIZER -- requirements
Module: packet_deserializer

---
 rtl/packet_deserializer_pkg.sv | 14 +
 rtl/packet_deserializer_sync_detector.sv | 41 ++++
 rtl/packet_deserializer.sv | 124 ++++++++++++
 tb/tb_packet_deserializer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/packet_deserializer_pkg.sv
// Shared packet-framing parameters and state encoding for the serializer/deserializer pair.
package packet_deserializer_pkg;

    localparam int unsigned DEFAULT_PACKET_SIZE = 192;
    localparam int unsigned DEFAULT_SYNC_WIDTH  = 8;
    localparam logic [DEFAULT_SYNC_WIDTH-1:0] DEFAULT_SYNC_WORD = 8'hFF;

    // Framing state: hunting for the sync word, or collecting a packet body
    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } deser_state_e;

endpackage

// File: rtl/packet_deserializer_sync_detector.sv
// Sync-word detector: sliding window over the serial stream, compared against the sync pattern.
module sync_detector #(
    parameter int unsigned SYNC_WIDTH = 8,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD = '1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic shift_en,
    input  logic clear,
    input  logic bit_in,
    output logic match_c
);

    // Only the older SYNC_WIDTH-1 bits are stored; the live bit completes the window
    logic [SYNC_WIDTH-2:0] shreg_q;
    logic [SYNC_WIDTH-2:0] shreg_d;
    logic [SYNC_WIDTH-1:0] window;

    assign window  = {shreg_q, bit_in};
    assign match_c = (window == SYNC_WORD);

    // Next shifter contents: clear wins so stale bits never re-trigger a lock
    always_comb begin
        shreg_d = shreg_q;
        if (clear) begin
            shreg_d = '0;
        end else if (shift_en) begin
            shreg_d = window[SYNC_WIDTH-2:0];
        end
    end

    // Shifter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/packet_deserializer.sv
// Serial-to-parallel packet deserializer with sync-word framing and a one-deep output holding register.
module packet_deserializer
    import packet_deserializer_pkg::*;
#(
    parameter int unsigned PACKET_SIZE = DEFAULT_PACKET_SIZE,
    parameter int unsigned SYNC_WIDTH  = DEFAULT_SYNC_WIDTH,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD = SYNC_WIDTH'(DEFAULT_SYNC_WORD)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    output logic [PACKET_SIZE-1:0] packet_out,
    output logic                   packet_valid,
    input  logic                   packet_ready,
    output logic                   sync_lock,
    output logic                   overflow
);

    localparam int unsigned CNT_W = $clog2(PACKET_SIZE + 1);

    deser_state_e           state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    // The final bit is appended on the fly, so the shifter holds PACKET_SIZE-1 bits
    logic [PACKET_SIZE-2:0] pkt_sh_q, pkt_sh_d;
    logic [PACKET_SIZE-1:0] packet_out_q, packet_out_d;
    logic                   packet_valid_q, packet_valid_d;
    logic                   overflow_q, overflow_d;

    logic                   hunt_shift_c;
    logic                   sync_clear_c;
    logic                   match_c;
    logic                   handshake_c;
    logic [CNT_W-1:0]       cnt_inc_c;
    logic [PACKET_SIZE-1:0] pkt_next_c;

    assign hunt_shift_c = bit_valid && (state_q == HUNT);
    assign handshake_c  = packet_valid_q && packet_ready;
    assign cnt_inc_c    = cnt_q + CNT_W'(1);
    assign pkt_next_c   = {pkt_sh_q, bit_in};

    sync_detector #(
        .SYNC_WIDTH (SYNC_WIDTH),
        .SYNC_WORD  (SYNC_WORD)
    ) u_sync_detector (
        .clock    (clock),
        .reset_n  (reset_n),
        .shift_en (hunt_shift_c),
        .clear    (sync_clear_c),
        .bit_in   (bit_in),
        .match_c  (match_c)
    );

    // Next-state: framing FSM, bit counter, packet shifter and output holding register
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pkt_sh_d       = pkt_sh_q;
        packet_out_d   = packet_out_q;
        packet_valid_d = packet_valid_q;
        overflow_d     = 1'b0;
        sync_clear_c   = 1'b0;

        if (handshake_c) begin
            packet_valid_d = 1'b0;
        end

        unique case (state_q)
            HUNT: begin
                if (bit_valid && match_c) begin
                    state_d  = COLLECT;
                    pkt_sh_d = (PACKET_SIZE-1)'(SYNC_WORD);
                    cnt_d    = CNT_W'(SYNC_WIDTH);
                end
            end
            COLLECT: begin
                if (bit_valid) begin
                    pkt_sh_d = pkt_next_c[PACKET_SIZE-2:0];
                    cnt_d    = cnt_inc_c;
                    if (cnt_inc_c == CNT_W'(PACKET_SIZE)) begin
                        state_d      = HUNT;
                        cnt_d        = '0;
                        sync_clear_c = 1'b1;
                        // A slot is free if empty or being drained this very cycle
                        if (!packet_valid_q || handshake_c) begin
                            packet_out_d   = pkt_next_c;
                            packet_valid_d = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= HUNT;
            cnt_q          <= '0;
            pkt_sh_q       <= '0;
            packet_out_q   <= '0;
            packet_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pkt_sh_q       <= pkt_sh_d;
            packet_out_q   <= packet_out_d;
            packet_valid_q <= packet_valid_d;
            overflow_q     <= overflow_d;
        end
    end

    assign packet_out   = packet_out_q;
    assign packet_valid = packet_valid_q;
    assign overflow     = overflow_q;
    assign sync_lock    = (state_q == COLLECT);

endmodule

// File: tb/tb_packet_deserializer.sv
// Directed bench for packet_deserializer: table of framed packets plus hand-written handshake/reset sequences.
module tb_packet_deserializer;

    localparam int unsigned PS = 192;

    localparam logic [PS-1:0] P0 = 192'hff5468697320697320612074657374206d65737361676521;
    localparam logic [PS-1:0] P1 = 192'hFFFF00FFA55AFF123456789ABCDEFFFF00FFFF0012345678;
    localparam logic [PS-1:0] P2 = 192'hFF0000000000000000000000000000000000000000000001;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          bit_in;
    logic          bit_valid;
    logic          packet_ready;
    logic [PS-1:0] packet_out;
    logic          packet_valid;
    logic          sync_lock;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [PS-1:0] pkt;
        int            pre_zeros;
        int            gap;
        logic [PS-1:0] exp_out;
    } vec_t;

    vec_t vecs[4];

    packet_deserializer #(
        .PACKET_SIZE (PS),
        .SYNC_WIDTH  (8),
        .SYNC_WORD   (8'hFF)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .packet_out   (packet_out),
        .packet_valid (packet_valid),
        .packet_ready (packet_ready),
        .sync_lock    (sync_lock),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_vec(input string name, input logic [PS-1:0] act, input logic [PS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n      = 1'b0;
        bit_valid    = 1'b0;
        packet_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // Idle-line zeros before a packet; lock must never assert on them
    task automatic send_zeros(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            bit_in    = 1'b0;
            bit_valid = 1'b1;
            @(negedge clock);
            bit_valid = 1'b0;
            chk_bit("lock_on_zeros", sync_lock, 1'b0);
            repeat (gap - 1) @(negedge clock);
        end
    endtask

    // Send the first nbits of pkt MSB first; checks run at the negedge after each captured bit
    task automatic send_packet(input logic [PS-1:0] pkt, input int nbits, input int gap,
                               input bit chk_pv, input bit ready_last, input bit chk_lock);
        logic [PS-1:0] p;
        p = pkt;
        for (int i = 0; i < nbits; i++) begin
            bit_in    = p[PS-1-i];
            bit_valid = 1'b1;
            if (ready_last && (i == nbits - 1)) packet_ready = 1'b1;
            @(negedge clock);
            bit_valid    = 1'b0;
            packet_ready = 1'b0;
            if (chk_lock) chk_bit("sync_lock_bit", sync_lock, (i >= 7) && (i < PS - 1));
            if (chk_pv)   chk_bit("packet_valid_bit", packet_valid, (i == PS - 1));
            repeat (gap - 1) @(negedge clock);
        end
    endtask

    task automatic consume();
        packet_ready = 1'b1;
        @(negedge clock);
        packet_ready = 1'b0;
        chk_bit("pv_after_consume", packet_valid, 1'b0);
    endtask

    initial begin
        reset_n      = 1'b0;
        bit_in       = 1'b0;
        bit_valid    = 1'b0;
        packet_ready = 1'b0;

        vecs[0] = '{pkt: P0, pre_zeros: 0,  gap: 10, exp_out: P0};
        vecs[1] = '{pkt: P0, pre_zeros: 20, gap: 1,  exp_out: P0};
        vecs[2] = '{pkt: P1, pre_zeros: 0,  gap: 1,  exp_out: P1};
        vecs[3] = '{pkt: P2, pre_zeros: 5,  gap: 3,  exp_out: P2};

        // Table: each packet from a clean reset, checked bit by bit and at completion
        for (int v = 0; v < 4; v++) begin
            do_reset();
            chk_vec("reset_packet_out", packet_out, '0);
            chk_bit("reset_packet_valid", packet_valid, 1'b0);
            chk_bit("reset_sync_lock", sync_lock, 1'b0);
            chk_bit("reset_overflow", overflow, 1'b0);
            send_zeros(vecs[v].pre_zeros, vecs[v].gap);
            send_packet(vecs[v].pkt, PS, vecs[v].gap, 1'b1, 1'b0, 1'b1);
            chk_vec("table_packet_out", packet_out, vecs[v].exp_out);
            chk_bit("table_overflow", overflow, 1'b0);
            @(negedge clock);
            chk_bit("table_pv_held", packet_valid, 1'b1);
            chk_vec("table_out_held", packet_out, vecs[v].exp_out);
            consume();
        end

        // Two packets with ready held low: first retained, one overflow pulse
        do_reset();
        send_packet(P0, PS, 1, 1'b1, 1'b0, 1'b1);
        chk_vec("ovf_first_out", packet_out, P0);
        send_packet(P2, PS, 1, 1'b0, 1'b0, 1'b1);
        chk_bit("ovf_pulse", overflow, 1'b1);
        chk_bit("ovf_pv", packet_valid, 1'b1);
        chk_vec("ovf_out_kept", packet_out, P0);
        @(negedge clock);
        chk_bit("ovf_pulse_end", overflow, 1'b0);
        chk_vec("ovf_out_kept2", packet_out, P0);

        // Handshake in the same cycle as completion: new packet loads, no overflow
        send_packet(P2, PS, 1, 1'b0, 1'b1, 1'b1);
        chk_vec("same_cycle_out", packet_out, P2);
        chk_bit("same_cycle_pv", packet_valid, 1'b1);
        chk_bit("same_cycle_ovf", overflow, 1'b0);
        @(negedge clock);
        chk_bit("same_cycle_ovf2", overflow, 1'b0);
        chk_bit("same_cycle_pv2", packet_valid, 1'b1);
        consume();

        // Reset mid-collect with a held packet: everything clears, next packet is clean
        send_packet(P1, PS, 1, 1'b1, 1'b0, 1'b1);
        chk_vec("pre_rst_out", packet_out, P1);
        send_packet(P0, 100, 2, 1'b0, 1'b0, 1'b1);
        chk_bit("mid_collect_lock", sync_lock, 1'b1);
        reset_n = 1'b0;
        #1;
        chk_vec("async_rst_out", packet_out, '0);
        chk_bit("async_rst_pv", packet_valid, 1'b0);
        chk_bit("async_rst_lock", sync_lock, 1'b0);
        chk_bit("async_rst_ovf", overflow, 1'b0);
        repeat (3) @(negedge clock);
        chk_vec("in_rst_out", packet_out, '0);
        reset_n = 1'b1;
        @(negedge clock);
        chk_bit("post_rst_lock", sync_lock, 1'b0);
        send_packet(P0, PS, 2, 1'b1, 1'b0, 1'b1);
        chk_vec("post_rst_out", packet_out, P0);
        chk_bit("post_rst_ovf", overflow, 1'b0);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
